// File: rtl/wta_pkg.sv
// Shared types and constants for the winner-take-all scheduler.
// Holds the FSM state encoding and the channel slice helper.
package wta_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  localparam int NUM_CH_DEF = 8;
  localparam int W_DEF      = 4;

  function automatic int ch_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/wta_cmp.sv
// Shared candidate comparator for the sequential WTA scan.
// Ties take the newer channel, so the highest index among equals wins.
module wta_cmp #(
  parameter int W = 4
) (
  input  logic         eligible,
  input  logic [W-1:0] value,
  input  logic [W-1:0] best_val,
  output logic         take
);

  assign take = eligible && (value != '0) && (value >= best_val);

endmodule

// File: rtl/wta_scheduler.sv
// Sequential winner-take-all scheduler: snapshot, scan one channel
// per cycle through a single comparator, report the strongest.
module wta_scheduler
  import wta_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int W      = W_DEF,
  localparam int IW    = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_CH*W-1:0] currents,
  input  logic [NUM_CH-1:0]   mask,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [IW-1:0]       winner_idx,
  output logic [W-1:0]        winner_val,
  output logic [NUM_CH-1:0]   winner_onehot
);

  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       k_q, k_d;
  logic [NUM_CH*W-1:0] cur_q, cur_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [W-1:0]        best_val_q, best_val_d;
  logic [IW-1:0]       best_idx_q, best_idx_d;
  logic                best_found_q, best_found_d;
  logic                found_q, found_d;
  logic [IW-1:0]       widx_q, widx_d;
  logic [W-1:0]        wval_q, wval_d;
  logic [NUM_CH-1:0]   woh_q, woh_d;

  logic [W-1:0] val_k;
  logic         elig_k;
  logic         take;
  logic         fin_found;
  logic [IW-1:0] fin_idx;
  logic [W-1:0] fin_val;

  always_comb begin
    val_k = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (k_q == IW'(i)) val_k = cur_q[ch_off(i, W) +: W];
    end
    elig_k = mask_q[k_q];
  end

  wta_cmp #(.W(W)) u_cmp (
    .eligible (elig_k),
    .value    (val_k),
    .best_val (best_val_q),
    .take     (take)
  );

  // Final result includes the channel evaluated on the last scan cycle.
  assign fin_found = take | best_found_q;
  assign fin_idx   = take ? k_q   : best_idx_q;
  assign fin_val   = take ? val_k : best_val_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cur_d        = cur_q;
    mask_d       = mask_q;
    best_val_d   = best_val_q;
    best_idx_d   = best_idx_q;
    best_found_d = best_found_q;
    found_d      = found_q;
    widx_d       = widx_q;
    wval_d       = wval_q;
    woh_d        = woh_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          cur_d        = currents;
          mask_d       = mask;
          k_d          = '0;
          best_val_d   = '0;
          best_idx_d   = '0;
          best_found_d = 1'b0;
        end
      end
      SCAN: begin
        if (take) begin
          best_val_d   = val_k;
          best_idx_d   = k_q;
          best_found_d = 1'b1;
        end
        if (k_q == LAST) begin
          state_d = DONE;
          found_d = fin_found;
          widx_d  = fin_idx;
          wval_d  = fin_val;
          woh_d   = fin_found ? (NUM_CH'(1) << fin_idx) : '0;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      cur_q        <= '0;
      mask_q       <= '0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      best_found_q <= 1'b0;
      found_q      <= 1'b0;
      widx_q       <= '0;
      wval_q       <= '0;
      woh_q        <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cur_q        <= cur_d;
      mask_q       <= mask_d;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      best_found_q <= best_found_d;
      found_q      <= found_d;
      widx_q       <= widx_d;
      wval_q       <= wval_d;
      woh_q        <= woh_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign found         = found_q;
  assign winner_idx    = widx_q;
  assign winner_val    = wval_q;
  assign winner_onehot = woh_q;

endmodule

// File: tb/tb_wta_scheduler.sv
// Scoreboard bench for wta_scheduler: expectations queued at start,
// popped and compared when done pulses.
module tb_wta_scheduler;

  localparam int N = 8;
  localparam int W = 4;
  localparam logic [31:0] BASE = 32'h4501_9293;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  currents = '0;
  logic [7:0]   mask = '0;
  logic         busy, done, found;
  logic [2:0]   winner_idx;
  logic [3:0]   winner_val;
  logic [7:0]   winner_onehot;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
    logic [3:0] val;
    logic [7:0] oh;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wta_scheduler #(.NUM_CH(N), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .currents      (currents),
    .mask          (mask),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .winner_idx    (winner_idx),
    .winner_val    (winner_val),
    .winner_onehot (winner_onehot)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] cur, input logic [7:0] msk);
    exp_t e;
    logic [3:0] v;
    e = '0;
    for (int i = 0; i < N; i++) begin
      v = cur[i*W +: W];
      if (msk[i] && v != 4'd0 && v >= e.val) begin
        e.found = 1'b1;
        e.idx   = 3'(i);
        e.val   = v;
      end
    end
    e.oh = e.found ? (8'd1 << e.idx) : 8'd0;
    return e;
  endfunction

  task automatic do_scan(input logic [31:0] cur, input logic [7:0] msk,
                         input exp_t e, input string nm);
    exp_t g;
    int ndone = 0;
    int dcyc = -1;
    sb.push_back(e);
    currents = cur;
    mask     = msk;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      checks++;
      if (busy !== 1'(c <= N + 1)) begin
        errors++;
        $display("FAIL %s busy c%0d: got %b want %b", nm, c, busy, (c <= N + 1));
      end
      if (done === 1'b1) begin
        ndone++;
        dcyc = c;
        if (sb.size() != 0) begin
          g = sb.pop_front();
          checks++;
          if ({found, winner_idx, winner_val, winner_onehot} !== g) begin
            errors++;
            $display("FAIL %s result: got f=%b i=%0d v=%0d oh=%h want f=%b i=%0d v=%0d oh=%h",
                     nm, found, winner_idx, winner_val, winner_onehot,
                     g.found, g.idx, g.val, g.oh);
          end
        end
      end
      tick();
    end
    checks++;
    if (ndone != 1 || dcyc != N + 1) begin
      errors++;
      $display("FAIL %s done: got %0d pulses at c%0d want 1 at c%0d", nm, ndone, dcyc, N + 1);
    end
    while (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, found, winner_idx, winner_val, winner_onehot} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got b=%b d=%b f=%b i=%0d v=%0d oh=%h want all 0",
               busy, done, found, winner_idx, winner_val, winner_onehot);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_scan(BASE, 8'hFF, '{1'b1, 3'd3, 4'd9, 8'h08}, "basic");
  endtask

  task automatic test_masked();
    do_scan(BASE, 8'hF7, '{1'b1, 3'd1, 4'd9, 8'h02}, "masked");
  endtask

  task automatic test_none();
    do_scan(32'h0, 8'hFF, '{1'b0, 3'd0, 4'd0, 8'h00}, "all_zero");
    do_scan(BASE, 8'h00, '{1'b0, 3'd0, 4'd0, 8'h00}, "mask_zero");
  endtask

  task automatic test_tie();
    do_scan(32'h7777_7777, 8'hFF, '{1'b1, 3'd7, 4'd7, 8'h80}, "tie_all");
    do_scan(32'h7777_7777, 8'h7F, '{1'b1, 3'd6, 4'd7, 8'h40}, "tie_mask");
    do_scan(32'hF000_000F, 8'hFF, '{1'b1, 3'd7, 4'd15, 8'h80}, "tie_max");
  endtask

  task automatic test_random();
    logic [31:0] cur;
    logic [7:0]  msk;
    for (int i = 0; i < 6; i++) begin
      cur = $urandom;
      msk = 8'($urandom);
      do_scan(cur, msk, model(cur, msk), "random");
    end
  endtask

  task automatic test_back_to_back();
    exp_t g;
    int ndone = 0;
    currents = BASE;
    mask     = 8'hFF;
    for (int c = 0; c <= 22; c++) begin
      if (done === 1'b1) begin
        ndone++;
        checks++;
        if (c != 9 && c != 19) begin
          errors++;
          $display("FAIL b2b done_cycle: got c%0d want c9 or c19", c);
        end
        if (sb.size() != 0) begin
          g = sb.pop_front();
          checks++;
          if ({found, winner_idx, winner_val, winner_onehot} !== g) begin
            errors++;
            $display("FAIL b2b result c%0d: got f=%b i=%0d v=%0d oh=%h want f=%b i=%0d v=%0d oh=%h",
                     c, found, winner_idx, winner_val, winner_onehot,
                     g.found, g.idx, g.val, g.oh);
          end
        end
      end
      if (c == 10) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b idle_c10: got busy=%b want 0", busy);
        end
      end
      if (c == 15) begin
        checks++;
        if (winner_idx !== 3'd3 || winner_val !== 4'd9) begin
          errors++;
          $display("FAIL b2b hold: got i=%0d v=%0d want i=3 v=9", winner_idx, winner_val);
        end
      end
      start = (c == 0 || c == 3 || c == 9 || c == 10);
      if (c == 0) sb.push_back('{1'b1, 3'd3, 4'd9, 8'h08});
      if (c == 10) sb.push_back('{1'b1, 3'd7, 4'd15, 8'h80});
      if (c == 2) currents = 32'hFFFF_FFFF;
      tick();
    end
    start = 1'b0;
    checks++;
    if (ndone != 2 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b count: got %0d dones, %0d pending want 2, 0", ndone, sb.size());
    end
    while (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_mid_scan_reset();
    int ndone = 0;
    currents = BASE;
    mask     = 8'hFF;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, found, winner_idx, winner_val, winner_onehot} !== '0) begin
      errors++;
      $display("FAIL async_rst outputs: got b=%b d=%b f=%b i=%0d v=%0d oh=%h want all 0",
               busy, done, found, winner_idx, winner_val, winner_onehot);
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: got %0d dones busy=%b want 0 dones busy=0", ndone, busy);
    end
    do_scan(BASE, 8'hF7, '{1'b1, 3'd1, 4'd9, 8'h02}, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_none();
    test_tie();
    test_basic();
    test_mid_scan_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wta_scheduler.md
# wta_scheduler

Sequential winner-take-all scheduler for the WTA demo datapath. Captures a snapshot of `NUM_CH` W-bit channel "currents", scans them one per cycle with a single shared comparator, and reports the strongest eligible channel. Ties go to the higher channel index, matching the nibble WTA rule (upper ≥ lower wins). Sits between the input sampling logic and the `uo_out` display/readout path, with a start/done handshake.

## Interface
- `NUM_CH`, 8: number of competing channels, ≥ 2.
- `W`, 4: width of each channel value.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a new competition. Sampled only in IDLE.
- `currents`  in  NUM_CH*W: channel k is at `[k*W +: W]`. Sampled on the accepted `start` edge only.
- `mask`  in  NUM_CH: eligibility per channel (1 = eligible). Sampled together with `currents`.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse; result outputs are valid from this cycle on.
- `found`  out  1: at least one eligible channel had a nonzero value.
- `winner_idx`  out  $clog2(NUM_CH): index of the winner.
- `winner_val`  out  W: value of the winner.
- `winner_onehot`  out  NUM_CH: one-hot form of `winner_idx`. All zero when `found` = 0.

## Operation
- FSM states:
  - IDLE: `start` = 1 → SCAN. On that edge, capture `currents` and `mask` into shadow registers, set k = 0, `best_val` = 0, `best_idx` = 0, `best_found` = 0.
  - SCAN: each cycle, evaluate channel k. It is a candidate if `mask[k]` = 1, `val[k]` ≠ 0, and `val[k]` ≥ `best_val`. A candidate updates best_* and sets `best_found`. Then k increments. After evaluating k = NUM_CH-1 → DONE.
  - DONE: one cycle. `done` = 1. Then → IDLE unconditionally.
- Result registers (`found`, `winner_idx`, `winner_val`, `winner_onehot`) load on the SCAN→DONE edge. They hold until the next SCAN→DONE edge.
- If no candidate exists: `found` = 0, `winner_idx` = 0, `winner_val` = 0, `winner_onehot` = 0.
- Tie rule: ≥ comparison in ascending scan order, so the highest index among equal maxima wins.
- `start` while `busy` (SCAN or DONE) is ignored. It is not queued.
- `currents`/`mask` changes after capture have no effect on the running scan.
- All comparisons are unsigned and W bits wide. No width extension. The k counter is $clog2(NUM_CH) bits and never wraps inside a scan.

## Timing
- Reset (async assert, any state): state = IDLE, `busy` = 0, `done` = 0, `found` = 0, `winner_idx` = 0, `winner_val` = 0, `winner_onehot` = 0. Shadow registers and the counter are also cleared.
- Reset mid-scan aborts the scan with no partial result. The first `start` after reset deassertion is accepted normally.
- Latency, with `start` high in cycle 0 in IDLE:
  - SCAN occupies cycles 1..NUM_CH.
  - `done` and the new results appear in cycle NUM_CH+1 (cycle 9 for NUM_CH = 8).
  - `busy` is high in cycles 1..NUM_CH+1.
  - The earliest next accepted `start` is in cycle NUM_CH+2.
- Throughput: one competition per NUM_CH+2 cycles.
- All outputs are registered. No combinational input→output path.

## Structure
- Package `wta_pkg`:
  - state enum (IDLE, SCAN, DONE);
  - default `NUM_CH` and `W` constants;
  - a function for the channel slice offset.
- Sub-module `wta_cmp`: combinational candidate check with inputs eligible, value, best_val and output take. It is instantiated once, as the shared comparator.
- Everything else (FSM, counter, shadow registers, result registers) lives in `wta_scheduler`.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately, `busy` = 0.
- Values ch0..7 = 3,9,2,9,1,0,5,4, `mask` = 0xFF, `start` in cycle 0 → `done` in cycle 9 only, `found` = 1, `winner_idx` = 3, `winner_val` = 9, `winner_onehot` = 0x08.
- Same values, `mask` = 0xF7 → `winner_idx` = 1, `winner_val` = 9, `winner_onehot` = 0x02.
- All values 0 with `mask` = 0xFF, or any values with `mask` = 0x00 → `found` = 0, `winner_idx` = 0, `winner_val` = 0, `winner_onehot` = 0.
- Run the first scan (expected `winner_idx` = 3). Then `start` pulses in cycles 3 and 9, and `currents` are changed to all 0xF in cycle 2 → result unchanged (`winner_idx` = 3), exactly one `done`. A `start` in cycle 10 is accepted, and that scan yields `winner_idx` = 7, `winner_val` = 15.
- `rst` pulse in cycle 4 of a scan → immediate IDLE with zeroed outputs, no `done`. A fresh `start` afterwards gives the correct result after NUM_CH+1 cycles.
